// File: rtl/scroller_pkg.sv
// Shared palette and LFSR step helpers for the parallax skyline scroller.
package scroller_pkg;

    localparam logic [8:0] LAYER0_BODY   = 9'b110_110_101;
    localparam logic [8:0] LAYER0_BORDER = 9'b011_011_110;
    localparam logic [8:0] SKY           = 9'b010_010_011;

    // Entry 0 is the front-layer body; deeper layers fade towards the sky tone.
    localparam logic [8:0] LAYER_COLOR [0:7] = '{
        9'b110_110_101,
        9'b010_010_100,
        9'b010_011_100,
        9'b010_011_011,
        9'b011_011_011,
        9'b011_011_011,
        9'b011_011_011,
        9'b011_011_011
    };

    function automatic logic [8:0] layer_color(input int unsigned k);
        if (k < 8) return LAYER_COLOR[k[2:0]];
        return SKY;
    endfunction

    // Forward step: shift left, feedback from bit w-1 and bit tap into bit 0.
    function automatic logic [31:0] lfsr_fwd(input logic [31:0] s, input int w, input int tap);
        logic [31:0] mask;
        mask = (32'h1 << w) - 32'h1;
        return ((s << 1) & mask) | {31'b0, s[w-1] ^ s[tap]};
    endfunction

    // Exact inverse of lfsr_fwd: bit w-1 recovers the shifted-out bit.
    function automatic logic [31:0] lfsr_bwd(input logic [31:0] n, input int w, input int tap);
        return (n >> 1) | ({31'b0, n[0] ^ n[tap+1]} << (w - 1));
    endfunction

endpackage

// File: rtl/parallax_layer.sv
// One building layer: base/working LFSR and phase, line cutoff and hit flag.
import scroller_pkg::*;

module parallax_layer #(
    parameter int LAYER    = 0,
    parameter int LFSR_W   = 9,
    parameter int TAP_B    = 4,
    parameter int HEIGHT_W = 4,
    parameter int COL_LOG2 = 3,
    parameter int ROW_LOG2 = 4,
    parameter int TOP      = 112
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       visible,
    input  logic       line_start,
    input  logic       advance,
    input  logic       dir,
    input  logic [9:0] vpos,
    output logic       hit,
    output logic       border
);

    localparam int PW = COL_LOG2 - LAYER;
    // A zero-width phase is kept as one constant bit that wraps every pixel.
    localparam int PR = (PW > 0) ? PW : 1;
    localparam int RS = ROW_LOG2 - LAYER;
    localparam logic [PR-1:0] PH_MAX = (PW > 0) ? {PR{1'b1}} : {PR{1'b0}};
    localparam logic [9:0] TOP_V = 10'(TOP);
    localparam logic [9:0] CUT_LIMIT = 10'(1 << HEIGHT_W);
    localparam logic [HEIGHT_W:0] CUT_MAX = {1'b1, {HEIGHT_W{1'b0}}};

    logic [LFSR_W-1:0]   base_lfsr, work_lfsr;
    logic [PR-1:0]       base_phase, work_phase;
    logic [HEIGHT_W:0]   cutoff, cutoff_next;
    logic [ROW_LOG2-1:0] row_lo;
    logic [9:0]          diff, shifted;

    // Height-step cutoff for the line being started, saturated at 2^HEIGHT_W.
    always_comb begin
        diff        = vpos - TOP_V;
        shifted     = diff >> RS;
        cutoff_next = '0;
        if (vpos < TOP_V)
            cutoff_next = '0;
        else if (shifted >= CUT_LIMIT)
            cutoff_next = CUT_MAX;
        else
            cutoff_next = shifted[HEIGHT_W:0];
    end

    // Base position: one pixel forward or backward per enabled frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_lfsr  <= '1;
            base_phase <= PH_MAX;
        end else if (advance) begin
            if (!dir) begin
                if (base_phase == PH_MAX) begin
                    base_phase <= '0;
                    base_lfsr  <= LFSR_W'(lfsr_fwd(32'(base_lfsr), LFSR_W, TAP_B));
                end else begin
                    base_phase <= base_phase + 1'b1;
                end
            end else begin
                if (base_phase == '0) begin
                    base_phase <= PH_MAX;
                    base_lfsr  <= LFSR_W'(lfsr_bwd(32'(base_lfsr), LFSR_W, TAP_B));
                end else begin
                    base_phase <= base_phase - 1'b1;
                end
            end
        end
    end

    // Working position: reload from base on line_start, walk one pixel per visible cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            work_lfsr  <= '1;
            work_phase <= PH_MAX;
        end else if (line_start) begin
            work_lfsr  <= base_lfsr;
            work_phase <= base_phase;
        end else if (visible) begin
            if (work_phase == PH_MAX) begin
                work_phase <= '0;
                work_lfsr  <= LFSR_W'(lfsr_fwd(32'(work_lfsr), LFSR_W, TAP_B));
            end else begin
                work_phase <= work_phase + 1'b1;
            end
        end
    end

    // Per-line cutoff and row offset within the current height step.
    always_ff @(posedge clk) begin
        if (rst) begin
            cutoff <= '0;
            row_lo <= '0;
        end else if (line_start) begin
            cutoff <= cutoff_next;
            row_lo <= diff[ROW_LOG2-1:0];
        end
    end

    assign hit    = {1'b0, work_lfsr[HEIGHT_W-1:0]} < cutoff;
    // Only the front layer draws an outline around its buildings.
    assign border = (LAYER == 0) &&
                    ((work_phase == '0) || (work_phase == PR'(1)) ||
                     (row_lo == '0) || (row_lo == '1));

endmodule

// File: rtl/parallax_engine.sv
// N-layer parallax skyline pixel generator: frame scroll control, priority select, output registers.
import scroller_pkg::*;

module parallax_engine #(
    parameter int NUM_LAYERS = 4,
    parameter int LFSR_W     = 9,
    parameter int TAP_B      = 4,
    parameter int HEIGHT_W   = 4,
    parameter int COL_LOG2   = 3,
    parameter int ROW_LOG2   = 4,
    parameter int TOP_Y      = 112,
    parameter int TOP_STEP   = 64
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                visible,
    input  logic                                line_start,
    input  logic                                frame_start,
    input  logic [9:0]                          vpos,
    input  logic                                pause,
    input  logic                                dir,
    output logic [8:0]                          rgb,
    output logic [$clog2(NUM_LAYERS+1)-1:0]     layer_id
);

    localparam int ID_W = $clog2(NUM_LAYERS + 1);

    logic [NUM_LAYERS-1:0] frame_cnt;
    logic [NUM_LAYERS-1:0] advance;
    logic [NUM_LAYERS-1:0] hit;
    logic [NUM_LAYERS-1:0] border;
    logic [8:0]            sel_rgb;
    logic [ID_W-1:0]       sel_id;
    logic                  found;

    // Frame counter paces the deeper layers; paused frames do not count.
    always_ff @(posedge clk) begin
        if (rst)
            frame_cnt <= '0;
        else if (frame_start && !pause)
            frame_cnt <= frame_cnt + 1'b1;
    end

    for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_layer
        localparam logic [NUM_LAYERS-1:0] LOW_MASK = NUM_LAYERS'((1 << k) - 1);

        assign advance[k] = frame_start && !pause && ((frame_cnt & LOW_MASK) == '0);

        parallax_layer #(
            .LAYER    (k),
            .LFSR_W   (LFSR_W),
            .TAP_B    (TAP_B),
            .HEIGHT_W (HEIGHT_W),
            .COL_LOG2 (COL_LOG2),
            .ROW_LOG2 (ROW_LOG2),
            .TOP      (TOP_Y + k * TOP_STEP)
        ) u_layer (
            .clk        (clk),
            .rst        (rst),
            .visible    (visible),
            .line_start (line_start),
            .advance    (advance[k]),
            .dir        (dir),
            .vpos       (vpos),
            .hit        (hit[k]),
            .border     (border[k])
        );
    end

    // Frontmost hitting layer wins; otherwise sky.
    always_comb begin
        sel_rgb = SKY;
        sel_id  = ID_W'(NUM_LAYERS);
        found   = 1'b0;
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            if (!found && hit[i]) begin
                found   = 1'b1;
                sel_id  = ID_W'(i);
                sel_rgb = border[i] ? LAYER0_BORDER : layer_color(i);
            end
        end
    end

    // Registered pixel output, blanked outside the active area.
    always_ff @(posedge clk) begin
        if (rst || !visible) begin
            rgb      <= '0;
            layer_id <= ID_W'(NUM_LAYERS);
        end else begin
            rgb      <= sel_rgb;
            layer_id <= sel_id;
        end
    end

endmodule

// File: tb/tb_parallax_engine.sv
// Scoreboard bench for parallax_engine with a position-based reference model.
module tb_parallax_engine;

    localparam logic [8:0] C_BODY   = 9'b110_110_101;
    localparam logic [8:0] C_BORDER = 9'b011_011_110;
    localparam logic [8:0] C_SKY    = 9'b010_010_011;
    localparam logic [8:0] C_L1     = 9'b010_010_100;
    localparam logic [8:0] C_L2     = 9'b010_011_100;
    localparam logic [8:0] C_L3     = 9'b010_011_011;
    localparam int OFF = 1024;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       visible = 1'b0;
    logic       line_start = 1'b0;
    logic       frame_start = 1'b0;
    logic [9:0] vpos = '0;
    logic       pause = 1'b0;
    logic       dir = 1'b0;
    logic [8:0] rgb;
    logic [2:0] layer_id;

    always #5 clk = ~clk;

    parallax_engine dut (
        .clk         (clk),
        .rst         (rst),
        .visible     (visible),
        .line_start  (line_start),
        .frame_start (frame_start),
        .vpos        (vpos),
        .pause       (pause),
        .dir         (dir),
        .rgb         (rgb),
        .layer_id    (layer_id)
    );

    always @(posedge clk) assert (!(line_start && visible)) else $error("line_start together with visible");

    // Model: each layer is an integer pixel position; LFSR value = sequence[pos >> phase_bits].
    int seq_tab [4096];
    int bpos [4];
    int wpos [4];
    int cut [4];
    int d0lo;
    int fc;
    logic cur_pause = 1'b0;
    logic cur_dir = 1'b0;
    string tname = "reset";

    logic [11:0] expq [$];
    int vectors = 0;
    int miscompares = 0;

    function automatic int lf_at(input int n);
        if (n + OFF < 0 || n + OFF > 4095) return -1;
        return seq_tab[n + OFF];
    endfunction

    function automatic void build_seq();
        seq_tab[OFF] = 9'h1FF;
        for (int i = OFF + 1; i < 4096; i++) begin
            int s = seq_tab[i-1];
            seq_tab[i] = ((s << 1) & 511) | (((s >> 8) ^ (s >> 4)) & 1);
        end
        for (int i = OFF - 1; i >= 0; i--) begin
            int n = seq_tab[i+1];
            seq_tab[i] = (n >> 1) | (((n ^ (n >> 5)) & 1) << 8);
        end
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 4; k++) begin
            bpos[k] = (1 << (3 - k)) - 1;
            wpos[k] = bpos[k];
            cut[k]  = 0;
        end
        d0lo = 0;
        fc   = 0;
    endfunction

    function automatic int cutoff_of(input int vp, input int k);
        int top = 112 + 64 * k;
        int c;
        if (vp < top) return 0;
        c = (vp - top) >> (4 - k);
        return (c > 16) ? 16 : c;
    endfunction

    function automatic logic [11:0] model_pixel();
        for (int k = 0; k < 4; k++) begin
            int pw = 3 - k;
            int ph = wpos[k] & ((1 << pw) - 1);
            int h  = lf_at(wpos[k] >>> pw) & 15;
            if (h < cut[k]) begin
                logic [2:0] id = 3'(k);
                case (k)
                    0: begin
                        if (ph < 2 || d0lo == 0 || d0lo == 15) return {C_BORDER, id};
                        return {C_BODY, id};
                    end
                    1: return {C_L1, id};
                    2: return {C_L2, id};
                    default: return {C_L3, id};
                endcase
            end
        end
        return {C_SKY, 3'd4};
    endfunction

    // One clock of stimulus: drive inputs, predict this cycle's output, advance the model.
    task automatic tick(input logic r, input logic v, input logic ls, input logic fs, input int vp);
        logic [11:0] e;
        @(posedge clk);
        #2;
        rst = r; visible = v; line_start = ls; frame_start = fs; vpos = 10'(vp);
        pause = cur_pause; dir = cur_dir;
        if (r) begin
            model_reset();
            e = {9'b0, 3'd4};
        end else begin
            e = v ? model_pixel() : {9'b0, 3'd4};
            if (ls) begin
                for (int k = 0; k < 4; k++) begin
                    wpos[k] = bpos[k];
                    cut[k]  = cutoff_of(vp, k);
                end
                d0lo = (vp - 112) & 15;
            end else if (v) begin
                for (int k = 0; k < 4; k++) wpos[k]++;
            end
            if (fs && !cur_pause) begin
                for (int k = 0; k < 4; k++)
                    if ((fc % (1 << k)) == 0) bpos[k] += cur_dir ? -1 : 1;
                fc = (fc + 1) % 16;
            end
        end
        expq.push_back(e);
    endtask

    task automatic line(input int vp, input int npix, input bit gaps);
        tick(0, 0, 1, 0, vp);
        tick(0, 0, 0, 0, vp);
        for (int i = 0; i < npix; i++)
            tick(0, (gaps && ($urandom % 16 == 0)) ? 1'b0 : 1'b1, 0, 0, vp);
        repeat (4) tick(0, 0, 0, 0, vp);
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            tick(0, 0, 0, 1, 500);
            tick(0, 0, 0, 0, 500);
        end
    endtask

    // Monitor: one expected entry per driven cycle, checked 1 time unit after the capturing edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                logic [11:0] e;
                e = expq.pop_front();
                vectors++;
                if ({rgb, layer_id} !== e) begin
                    miscompares++;
                    $display("FAIL %s @%0t: got rgb=%b id=%0d, want rgb=%b id=%0d",
                             tname, $time, rgb, layer_id, e[11:3], e[2:0]);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        build_seq();
        model_reset();

        tname = "reset";
        repeat (3) tick(1, 0, 0, 0, 0);
        repeat (2) tick(0, 0, 0, 0, 0);

        tname = "sky_line";
        line(100, 640, 0);

        tname = "saturated";
        line(368, 640, 0);
        line(369, 640, 0);

        tname = "cutoff1";
        line(128, 640, 0);
        line(129, 640, 0);

        tname = "fwd8";
        cur_dir = 1'b0;
        frames(8);
        line(369, 640, 0);

        tname = "rev8";
        cur_dir = 1'b1;
        frames(8);
        line(369, 640, 0);
        line(250, 640, 0);

        tname = "pause8";
        cur_pause = 1'b1;
        cur_dir = 1'b0;
        frames(8);
        line(369, 640, 0);
        cur_pause = 1'b0;

        tname = "ls_with_fs";
        frames(3);
        tick(0, 0, 1, 1, 369);
        tick(0, 0, 0, 0, 369);
        repeat (200) tick(0, 1, 0, 0, 369);
        repeat (3) tick(0, 0, 0, 0, 369);
        line(369, 640, 0);

        tname = "rst_mid_line";
        frames(5);
        tick(0, 0, 1, 0, 369);
        tick(0, 0, 0, 0, 369);
        repeat (300) tick(0, 1, 0, 0, 369);
        tick(1, 1, 0, 0, 369);
        repeat (100) tick(0, 1, 0, 0, 369);
        repeat (3) tick(0, 0, 0, 0, 369);
        line(369, 640, 0);

        tname = "random";
        for (int it = 0; it < 30; it++) begin
            int nf = $urandom_range(0, 6);
            for (int f = 0; f < nf; f++) begin
                cur_pause = ($urandom % 4 == 0);
                cur_dir   = $urandom % 2;
                frames(1);
            end
            if ($urandom % 6 == 0) begin
                tick(0, 0, 1, 1, $urandom_range(0, 479));
                repeat (2) tick(0, 0, 0, 0, 0);
            end
            if ($urandom % 10 == 0) begin
                tick(0, 0, 1, 0, $urandom_range(300, 479));
                tick(0, 0, 0, 0, 0);
                repeat ($urandom_range(1, 300)) tick(0, 1, 0, 0, 0);
                tick(1, 1, 0, 0, 0);
                repeat (20) tick(0, 1, 0, 0, 0);
                repeat (2) tick(0, 0, 0, 0, 0);
            end
            line($urandom_range(0, 479), 640, 1);
        end
        cur_pause = 1'b0;

        tname = "drain";
        repeat (3) @(posedge clk);
        #3;
        vectors++;
        if (expq.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending entries, want 0", expq.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/parallax_engine.md
# parallax_engine

Parametrised N-layer parallax skyline pixel generator for the VGA scroller. It sits between the external VGA sync generator and the colour ditherer, and emits one 3-bit-per-channel colour per pixel clock. Each layer is a pseudo-random strip of building heights produced by an LFSR, and the layers scroll at speeds that halve per depth. Over the two-layer predecessor it adds a configurable layer count and geometry, pause, reverse scrolling and a winning-layer output.

## Interface
Parameters:
- NUM_LAYERS, 4: building layers. Layer 0 is the front layer.
- LFSR_W, 9: LFSR width. The feedback taps are bit LFSR_W-1 and bit TAP_B.
- TAP_B, 4: second feedback tap. Must be < LFSR_W-2.
- HEIGHT_W, 4: LFSR low bits used as a column's building height.
- COL_LOG2, 3: log2 of the layer-0 column width in pixels. Layer k uses COL_LOG2-k. Requires COL_LOG2 ≥ NUM_LAYERS-1.
- ROW_LOG2, 4: log2 of the layer-0 lines per height step. Layer k uses ROW_LOG2-k. Requires ROW_LOG2 ≥ NUM_LAYERS-1.
- TOP_Y, 112: first line of layer 0. Layer k starts at TOP_Y + k*TOP_STEP.
- TOP_STEP, 64: line offset between the start lines of adjacent layers.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  reset, synchronous, active-high.
- visible  in  1  current cycle is an active pixel.
- line_start  in  1  one-cycle strobe, at least 1 cycle before the first visible pixel of each line.
- frame_start  in  1  one-cycle strobe once per frame, during vertical blanking.
- vpos  in  10  current line number. Sampled on line_start.
- pause  in  1  1 = freeze scrolling.
- dir  in  1  0 = scene moves left (forward), 1 = scene moves right (reverse).
- rgb  out  9  {r[2:0], g[2:0], b[2:0]}, registered.
- layer_id  out  clog2(NUM_LAYERS+1)  winning layer. Value NUM_LAYERS means sky.

## Operation
Per-layer state:
- base LFSR and base phase (COL_LOG2-k bits). Reset value is all-ones for both.
- working LFSR and working phase. Reset value is all-ones.
- cutoff register, HEIGHT_W+1 bits. Reset value is 0.

Pixel walk, on each cycle with visible=1:
- working phase increments.
- When the phase wraps from all-ones to 0, the working LFSR steps forward: next = {s[W-2:0], s[W-1]^s[TAP_B]}.

On line_start, for each layer k:
- working LFSR and phase load from base.
- With d = vpos − top_k: cutoff = 0 if vpos < top_k, else min(d >> (ROW_LOG2−k), 2^HEIGHT_W).

Frame scroll:
- A NUM_LAYERS-bit frame counter increments on every frame_start with pause=0.
- Layer k advances its base on a frame_start where pause=0 and the counter's low k bits are 0. Layer 0 therefore advances every frame.
- Forward advance (dir=0) uses the pixel-walk step.
- Reverse advance (dir=1): phase decrements. On a wrap from 0 to all-ones, the LFSR steps backward: prev = {n[0]^n[TAP_B+1], n[W-1:1]}.
- A forward advance followed by a reverse advance restores the base exactly.

Pixel select, evaluated in priority order:
- Lowest k with lfsr_k[HEIGHT_W-1:0] < cutoff_k wins.
- Layer 0 pixels are border colour when any of the following holds:
  - working phase is 0 or 1;
  - (d mod 2^ROW_LOG2) is 0;
  - (d mod 2^ROW_LOG2) is 2^ROW_LOG2−1.
- Layer 0 pixels that are not border are body colour.
- If no layer wins, the pixel is sky.
- When visible=0: rgb=0 and layer_id=NUM_LAYERS.

## Timing
- Latency from a pixel's visible cycle to its rgb/layer_id is 1 cycle.
- rgb and layer_id are registered. Reset values are rgb=0 and layer_id=NUM_LAYERS.
- While rst is high, all state holds its reset value.
- Reset mid-line forces rgb=0 on the next cycle.
- line_start and frame_start in the same cycle:
  - working state loads the pre-update base;
  - the new base takes effect from the next line_start.
- line_start with visible=1 in the same cycle: the load wins and the pixel-walk step is dropped. Such input is illegal; the bench asserts it never occurs.
- pause or dir changing mid-frame takes effect at the next frame_start.
- Saturation: cutoff never exceeds 2^HEIGHT_W. At saturation every column of that layer is building.

## Structure
- Package scroller_pkg holds:
  - palette constants: LAYER0_BODY 110/110/101, LAYER0_BORDER 011/011/110, LAYER_COLOR[k] for k ≥ 1 (layer 1 = 010/010/100, deeper layers progressively closer to sky), SKY 010/010/011;
  - LFSR forward/backward step functions.
- Sub-module parallax_layer is instantiated once per layer via generate. It holds base/working LFSR and phase, cutoff and the hit flag.
- The top level holds the frame counter, the priority select and the output registers.

## Test plan
The bench uses default parameters throughout.
1. Reset, then line_start at vpos=100 and 640 visible pixels → every rgb = SKY, layer_id=4.
2. Line at vpos=368 with base at reset → layer 0 cutoff=16, every pixel is layer 0. Pixels at phase 0/1 are BORDER and the rest are BODY.
3. Line at vpos=128 → layer-0 cutoff=1. Only columns whose LFSR low nibble is 0 are building, and pixels at line offset 0 are BORDER.
4. 8 frame_starts with pause=0, dir=0 → layer 0 base advanced 8 pixels (1 LFSR step), layer 3 base advanced 1 pixel. Rendered row 368 is shifted left by 8 pixels against a golden model.
5. 8 frames forward, then 8 frames with dir=1 → all bases equal the reset values (all-ones). 8 frames with pause=1 → bases unchanged.
6. rst asserted for 1 cycle mid-visible-line → rgb=0 the next cycle, and all bases return to all-ones.
